// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one dmem req/gnt/rvalid transaction per instruction.
// Optional feature macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [2:0]  ex_mem_op_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Access size code: 0 = byte, 1 = half, 2 = word.
    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
            default:              op_size = 2'd2;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    align_addr = addr;
            2'd1:    align_addr = {addr[31:1], 1'b0};
            default: align_addr = {addr[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_en = 4'b0001 << off;
            2'd1:    byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'd0:    store_data = {4{w[7:0]}};
            2'd1:    store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   load_data = {{24{sh[7]}}, sh[7:0]};
            OP_LH:   load_data = {{16{sh[15]}}, sh[15:0]};
            OP_LBU:  load_data = {24'd0, sh[7:0]};
            OP_LHU:  load_data = {16'd0, sh[15:0]};
            default: load_data = sh;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;

    logic        accept_s;
    logic        trap_s;
    logic [1:0]  size_s;
    logic [31:0] eff_addr_s;

    assign size_s     = op_size(ex_mem_op_i);
    assign eff_addr_s = align_addr(size_s, ex_addr_i);
    assign accept_s   = ex_valid_i && (state_q == ST_IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s     = misaligned(size_s, ex_addr_i[1:0]);
`else
    assign trap_s     = 1'b0;
`endif

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rd_d         = rd_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        misalign_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && trap_s) begin
                    misalign_d = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = ex_rd_i;
                    wb_data_d  = 32'd0;
                end else if (accept_s) begin
                    state_d      = ST_REQ;
                    op_d         = ex_mem_op_i;
                    off_d        = eff_addr_s[1:0];
                    rd_d         = ex_rd_i;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = op_is_store(ex_mem_op_i);
                    dmem_addr_d  = {eff_addr_s[31:2], 2'b00};
                    dmem_be_d    = byte_en(size_s, eff_addr_s[1:0]);
                    dmem_wdata_d = store_data(size_s, ex_wdata_i);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A response in the grant cycle is not legal, so only gnt is looked at here.
                if (dmem_gnt_i) begin
                    state_d    = ST_RESP;
                    dmem_req_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid_i) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !op_is_store(op_q) && (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = op_is_store(op_q) ? 32'd0 : load_data(op_q, off_q, dmem_rdata_i);
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
        end
    end

    assign ex_ready_o   = (state_q == ST_IDLE);
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = misalign_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the memory stage of the in-order RV32I core. It consumes the decoded `pipeline_bus_t` memory fields issued by execute, and only `mem_op` drives its behaviour. It runs one data-memory request/grant/response transaction per instruction and returns byte-lane-aligned, sign- or zero-extended load data to writeback. While a transaction is outstanding it holds off the pipeline with a ready/valid handshake.

## Interface
- No parameters. Address and data width are fixed at 32.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ex_valid_i` in 1: execute presents a memory instruction.
- `ex_ready_o` out 1: LSU can accept; an instruction is taken when `ex_valid_i && ex_ready_o`.
- `ex_mem_op_i` in 3: `core::MEM_OP_t` (LB/LH/LW/LBU/LHU/SB/SH/SW).
- `ex_addr_i` in 32: effective address from the ALU.
- `ex_wdata_i` in 32: rs2 value for stores.
- `ex_rd_i` in 5: load destination register.
- `dmem_req_o` in/out: out 1: request valid.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out 32: word address; bits [1:0] are always 0.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: store data replicated into lanes.
- `dmem_gnt_i` in 1: memory accepts the request.
- `dmem_rvalid_i` in 1: response valid, for loads and stores.
- `dmem_rdata_i` in 32: load word.
- `wb_valid_o` out 1: one-cycle completion pulse.
- `wb_we_o` out 1: register write enable (loads with `rd`≠0).
- `wb_rd_o` out 5, `wb_data_o` out 32: writeback target and value.
- `misalign_o` out 1: one-cycle pulse, misaligned access detected (see Configuration).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - `ex_ready_o`=1.
  - On accept, latch op, addr, wdata and rd, then go to REQ.
- REQ:
  - `dmem_req_o`=1, with `dmem_addr_o`/`dmem_be_o`/`dmem_wdata_o`/`dmem_we_o` held stable.
  - On `dmem_gnt_i`, go to RESP.
  - `req` must not drop before `gnt`.
- RESP:
  - `dmem_req_o`=0.
  - On `dmem_rvalid_i`, register the result, pulse `wb_valid_o` next cycle, and return to IDLE.
- `ex_ready_o`=0 in REQ and RESP. Back-to-back: IDLE is re-entered the cycle after rvalid, so a new accept can occur then.
- Byte enables from `addr[1:0]`:
  - byte: `1<<a`.
  - half: `4'b0011<<a` (a∈{0,2}).
  - word: `4'b1111`.
- Store data: byte replicated ×4, half ×2, word unchanged.
- Load extraction: select lane by `addr[1:0]`.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Stores complete with `wb_valid_o`=1, `wb_we_o`=0.
- `rdata` is ignored for stores.
- `dmem_rvalid_i` outside RESP is ignored.

## Timing
- Reset values:
  - state IDLE, `ex_ready_o`=1.
  - `dmem_req_o`=0, `dmem_we_o`=0, `dmem_addr_o`=0, `dmem_be_o`=0, `dmem_wdata_o`=0.
  - `wb_valid_o`=0, `wb_we_o`=0, `wb_rd_o`=0, `wb_data_o`=0, `misalign_o`=0.
- Latency with gnt and rvalid at the earliest cycles:
  - accept at cycle N, req at N+1 with gnt at N+1, rvalid at N+2, `wb_valid_o` at N+3.
  - Minimum issue-to-issue interval is 3 cycles.
- All dmem and wb outputs are registered. There is no combinational path from `dmem_*_i` to `dmem_*_o`.
- `rvalid` in the same cycle as `gnt` is not legal from memory; the LSU waits for the cycle after.
- Reset asserted mid-transaction returns to IDLE immediately, drops `req`, and produces no `wb_valid_o`. A late `rvalid` after reset release is ignored (state is IDLE).

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - A misaligned accept issues no dmem request.
  - The LSU goes IDLE→IDLE, pulsing `misalign_o` and `wb_valid_o` (with `wb_we_o`=0) in cycle N+1.
- Not defined:
  - `misalign_o` is tied 0.
  - The address is forced to natural alignment (half: clear bit 0; word: clear bits [1:0]) and the access proceeds normally.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF → `dmem_be_o`=1111, `dmem_addr_o`=0x100, `wb_data_o`=0xDEADBEEF, `wb_we_o`=1, rd echoed.
- LB and LBU at 0x103, word 0x80FF_0000 → LB gives 0xFFFFFF80, LBU gives 0x00000080; `be`=1000.
- SH at 0x102 with wdata 0x1234ABCD → `we`=1, `be`=1100, `dmem_wdata_o`=0xABCDABCD; completes with `wb_we_o`=0.
- gnt delayed 4 cycles and rvalid delayed 3 more → `req` and addr stable throughout, `ex_ready_o`=0 until rvalid, exactly one `wb_valid_o`.
- LW at 0x101:
  - with the macro: `misalign_o`=1, no `dmem_req_o`.
  - without the macro: access goes to 0x100.
- `rst_n` pulsed low while in RESP, then a stray rvalid → no wb pulse, state IDLE, all outputs at reset values.
